cpu_record_emitter: RTL

- Serialises one CPU write-back record per request into an ASCII character stream, one character per clock.
- Two record kinds are produced: register write `^<time>@<pc>: $<grf> <= <data>#` and memory write `^<time>@<pc>: *<addr> <= <data>#`.
- Sits at the trace end of the CPU and drives the same 8-bit character interface that the format checker consumes.
- Output is always well-formed: every emitted record classifies as Register (2'b01) or Storage (2'b10).

---
 rtl/cpu_trace_defs.sv | 45 ++++
 rtl/hex_ascii.sv | 18 +
 rtl/cpu_record_emitter.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/cpu_trace_defs.sv
// ============================================================================
// cpu_trace_defs : record type codes, ASCII constants and emitter FSM states
// Rev 1.0
// ============================================================================
`default_nettype none

package cpu_trace_defs;

  typedef enum logic [1:0] {
    REC_ERROR    = 2'b00,
    REC_REGISTER = 2'b01,
    REC_STORAGE  = 2'b10
  } rec_type_e;

  localparam logic [7:0] c_ASCII_CARET  = 8'h5E;
  localparam logic [7:0] c_ASCII_AT     = 8'h40;
  localparam logic [7:0] c_ASCII_COLON  = 8'h3A;
  localparam logic [7:0] c_ASCII_DOLLAR = 8'h24;
  localparam logic [7:0] c_ASCII_STAR   = 8'h2A;
  localparam logic [7:0] c_ASCII_LT     = 8'h3C;
  localparam logic [7:0] c_ASCII_EQ     = 8'h3D;
  localparam logic [7:0] c_ASCII_HASH   = 8'h23;
  localparam logic [7:0] c_ASCII_SPACE  = 8'h20;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_CARET = 4'd1,
    ST_TIME  = 4'd2,
    ST_AT    = 4'd3,
    ST_PC    = 4'd4,
    ST_COLON = 4'd5,
    ST_SP1   = 4'd6,
    ST_SIGIL = 4'd7,
    ST_ID    = 4'd8,
    ST_SP2   = 4'd9,
    ST_LT    = 4'd10,
    ST_EQ    = 4'd11,
    ST_SP3   = 4'd12,
    ST_DATA  = 4'd13,
    ST_HASH  = 4'd14
  } state_e;

endpackage

`default_nettype wire

// File: rtl/hex_ascii.sv
// ============================================================================
// hex_ascii : 4-bit nibble to lowercase ASCII hex digit ('0'-'9', 'a'-'f')
// Rev 1.0
// ============================================================================
`default_nettype none

module hex_ascii (
  input  logic [3:0] nibble_i,
  output logic [7:0] ascii_o
);

  // 'a' is 8'h61, so letters are offset from 8'h57
  assign ascii_o = (nibble_i < 4'd10) ? (8'h30 + {4'h0, nibble_i})
                                      : (8'h57 + {4'h0, nibble_i});

endmodule

`default_nettype wire

// File: rtl/cpu_record_emitter.sv
// ============================================================================
// cpu_record_emitter : serialises register/memory write-back records to ASCII
// Rev 1.0
// ============================================================================
`default_nettype none

module cpu_record_emitter
  import cpu_trace_defs::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_type,
  input  logic [13:0] req_time,
  input  logic [31:0] req_pc,
  input  logic [4:0]  req_grf,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic [7:0]  char_o,
  output logic        char_valid,
  output logic        char_last
);

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        is_mem_q;
  logic [13:0] time_q;
  logic [31:0] pc_q, addr_q, data_q;
  logic [4:0]  grf_q;
  logic [7:0]  char_q, char_d;
  logic        valid_q, valid_d, last_q, last_d;

  logic        w_start;
  logic [13:0] w_time_clamp;
  logic [3:0]  w_dec [4];
  logic [2:0]  w_tlast, w_glast, w_idlast;
  logic [4:0]  w_sh;
  logic [3:0]  w_nib;
  logic [7:0]  w_hex;

  assign req_ready    = (state_q == ST_IDLE) || (state_q == ST_HASH);
  assign w_start      = req_valid && req_ready &&
                        ((req_type == REC_REGISTER) || (req_type == REC_STORAGE));
  assign w_time_clamp = (req_time > 14'd9999) ? 14'd9999 : req_time;

  always_comb begin
    w_dec[3] = 4'(time_q / 14'd1000);
    w_dec[2] = 4'((time_q / 14'd100) % 14'd10);
    w_dec[1] = 4'((time_q / 14'd10) % 14'd10);
    w_dec[0] = 4'(time_q % 14'd10);
  end

  // Last digit index of each variable-length field (count of digits minus one)
  assign w_tlast  = (time_q >= 14'd1000) ? 3'd3 :
                    (time_q >= 14'd100)  ? 3'd2 :
                    (time_q >= 14'd10)   ? 3'd1 : 3'd0;
  assign w_glast  = (grf_q >= 5'd10) ? 3'd1 : 3'd0;
  assign w_idlast = is_mem_q ? 3'd7 : w_glast;

  always_comb begin
    state_d = state_q;
    cnt_d   = 3'd0;
    case (state_q)
      ST_IDLE:  if (w_start) state_d = ST_CARET;
      ST_CARET: state_d = ST_TIME;
      ST_TIME: begin
        if (cnt_q == w_tlast) state_d = ST_AT;
        else cnt_d = cnt_q + 3'd1;
      end
      ST_AT:    state_d = ST_PC;
      ST_PC: begin
        if (cnt_q == 3'd7) state_d = ST_COLON;
        else cnt_d = cnt_q + 3'd1;
      end
      ST_COLON: state_d = ST_SP1;
      ST_SP1:   state_d = ST_SIGIL;
      ST_SIGIL: state_d = ST_ID;
      ST_ID: begin
        if (cnt_q == w_idlast) state_d = ST_SP2;
        else cnt_d = cnt_q + 3'd1;
      end
      ST_SP2:   state_d = ST_LT;
      ST_LT:    state_d = ST_EQ;
      ST_EQ:    state_d = ST_SP3;
      ST_SP3:   state_d = ST_DATA;
      ST_DATA: begin
        if (cnt_q == 3'd7) state_d = ST_HASH;
        else cnt_d = cnt_q + 3'd1;
      end
      ST_HASH:  state_d = w_start ? ST_CARET : ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Character is chosen from the next state so the output register holds it
  assign w_sh = {3'd7 - cnt_d, 2'b00};

  always_comb begin
    w_nib = 4'h0;
    case (state_d)
      ST_TIME: w_nib = w_dec[2'(w_tlast - cnt_d)];
      ST_PC:   w_nib = pc_q[w_sh +: 4];
      ST_ID: begin
        if (is_mem_q)                              w_nib = addr_q[w_sh +: 4];
        else if ((w_glast == 3'd1) && (cnt_d == 3'd0)) w_nib = 4'(grf_q / 5'd10);
        else                                       w_nib = 4'(grf_q % 5'd10);
      end
      ST_DATA: w_nib = data_q[w_sh +: 4];
      default: w_nib = 4'h0;
    endcase
  end

  hex_ascii u_hex (
    .nibble_i (w_nib),
    .ascii_o  (w_hex)
  );

  always_comb begin
    char_d  = 8'h00;
    valid_d = (state_d != ST_IDLE);
    last_d  = (state_d == ST_HASH);
    case (state_d)
      ST_CARET: char_d = c_ASCII_CARET;
      ST_TIME,
      ST_PC,
      ST_ID,
      ST_DATA:  char_d = w_hex;
      ST_AT:    char_d = c_ASCII_AT;
      ST_COLON: char_d = c_ASCII_COLON;
      ST_SP1,
      ST_SP2,
      ST_SP3:   char_d = c_ASCII_SPACE;
      ST_SIGIL: char_d = is_mem_q ? c_ASCII_STAR : c_ASCII_DOLLAR;
      ST_LT:    char_d = c_ASCII_LT;
      ST_EQ:    char_d = c_ASCII_EQ;
      ST_HASH:  char_d = c_ASCII_HASH;
      default:  char_d = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= 3'd0;
      char_q   <= 8'h00;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
      is_mem_q <= 1'b0;
      time_q   <= 14'd0;
      pc_q     <= 32'h0;
      grf_q    <= 5'd0;
      addr_q   <= 32'h0;
      data_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      if (w_start) begin
        is_mem_q <= (req_type == REC_STORAGE);
        time_q   <= w_time_clamp;
        pc_q     <= req_pc;
        grf_q    <= req_grf;
        addr_q   <= req_addr;
        data_q   <= req_data;
      end
    end
  end

  assign char_o     = char_q;
  assign char_valid = valid_q;
  assign char_last  = last_q;

endmodule

`default_nettype wire
